// File: rtl/vga_draw_if.sv
// vga_draw_if: bundles the CPU command port and the screen-memory write port
// of vga_draw_engine.
//   cmd_wr/cmd_data     CPU pushes a command ({opcode[6:0], operand[8:0]})
//   cmd_full            command FIFO holds FIFO_DEPTH entries
//   busy                commands pending or a fill in progress
//   fifo_level          current FIFO entry count
//   err_overflow        sticky dropped-push flag, cleared by err_clr
//   mem_we/addr/wdata   pixel write request, held until mem_ready
//   mem_ready           memory accepts the write this cycle
// Modports: slave = engine side, master = CPU/memory side.
interface vga_draw_if #(
    parameter int XW         = 8,
    parameter int YW         = 9,
    parameter int CW         = 3,
    parameter int FIFO_DEPTH = 4
) ();
    logic                          cmd_wr;
    logic [15:0]                   cmd_data;
    logic                          cmd_full;
    logic                          busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          err_overflow;
    logic                          err_clr;
    logic                          mem_we;
    logic [YW+XW-1:0]              mem_addr;
    logic [CW-1:0]                 mem_wdata;
    logic                          mem_ready;

    modport slave (
        input  cmd_wr, cmd_data, err_clr, mem_ready,
        output cmd_full, busy, fifo_level, err_overflow,
               mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cmd_wr, cmd_data, err_clr, mem_ready,
        input  cmd_full, busy, fifo_level, err_overflow,
               mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_draw_engine.sv
// vga_draw_engine: queued draw-command executor in front of screen memory.
// Commands enter a show-ahead FIFO; register commands update x/y/xMax/yMax/
// color, draw commands (pixel, box, clear) rasterise one pixel per accepted
// memory write.
// Ports:
//   clk50   single rising-edge clock
//   reset   synchronous, active-high
//   bus     vga_draw_if.slave (command port, status, memory write port)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | pop one FIFO entry per cycle when non-empty
// FILL   | issue mem_we for the latched region until last pixel accepted
module vga_draw_engine #(
    parameter int XW         = 8,
    parameter int YW         = 9,
    parameter int CW         = 3,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk50,
    input  logic       reset,
    vga_draw_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    // Coordinate math is one bit wider so a bound of 2^XW-1 cannot wrap.
    localparam logic [XW:0] X_LIM = (XW+1)'(SCREEN_W);
    localparam logic [XW:0] X_END = (XW+1)'(SCREEN_W - 1);
    localparam logic [YW:0] Y_LIM = (YW+1)'(SCREEN_H);
    localparam logic [YW:0] Y_END = (YW+1)'(SCREEN_H - 1);

    localparam logic [6:0] OP_SET_X     = 7'd1;
    localparam logic [6:0] OP_SET_Y     = 7'd2;
    localparam logic [6:0] OP_SET_COLOR = 7'd3;
    localparam logic [6:0] OP_SET_XMAX  = 7'd5;
    localparam logic [6:0] OP_SET_YMAX  = 7'd6;
    localparam logic [6:0] OP_DRAW_BOX  = 7'd7;
    localparam logic [6:0] OP_CLEAR     = 7'd8;
    localparam logic [6:0] OP_DRAW_PIX  = 7'd9;

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    state_t state_q, state_d;

    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          err_q;
    logic          full, empty, push, pop, overflow;
    logic [15:0]   head;
    logic [6:0]    op;
    logic [8:0]    opnd;

    logic [XW-1:0] x_q, xmax_q;
    logic [YW-1:0] y_q, ymax_q;
    logic [CW-1:0] color_q, fill_color_q;

    logic [XW:0]   col_q, col_start_q, col_end_q;
    logic [YW:0]   row_q, row_end_q;

    logic [XW:0]   xs, xe, xmax_c;
    logic [YW:0]   ys, ye, ymax_c;
    logic          is_draw, region_empty, start_fill, last_px;

    assign full     = (count_q == LW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = bus.cmd_wr & ~full;
    // Full is taken from the pre-edge count, so a same-cycle pop does not
    // rescue a push made while full.
    assign overflow = bus.cmd_wr & full;
    assign head     = fifo_mem[rd_ptr_q];
    assign op       = head[15:9];
    assign opnd     = head[8:0];
    assign last_px  = (col_q == col_end_q) && (row_q == row_end_q);

    assign bus.cmd_full     = full;
    assign bus.fifo_level   = count_q;
    assign bus.err_overflow = err_q;
    assign bus.busy         = ~empty | (state_q != S_IDLE);
    assign bus.mem_we       = (state_q == S_FILL);
    assign bus.mem_addr     = {row_q[YW-1:0], col_q[XW-1:0]};
    assign bus.mem_wdata    = fill_color_q;

    always_ff @(posedge clk50) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= bus.cmd_data;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (overflow)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

    // Region bounds for the command at the FIFO head.
    always_comb begin
        xmax_c       = ({1'b0, xmax_q} > X_END) ? X_END : {1'b0, xmax_q};
        ymax_c       = ({1'b0, ymax_q} > Y_END) ? Y_END : {1'b0, ymax_q};
        xs           = {1'b0, x_q};
        ys           = {1'b0, y_q};
        xe           = xs;
        ye           = ys;
        is_draw      = 1'b0;
        region_empty = 1'b1;
        case (op)
            OP_DRAW_BOX: begin
                is_draw      = 1'b1;
                xe           = xmax_c;
                ye           = ymax_c;
                region_empty = (xmax_q < x_q) || (ymax_q < y_q) ||
                               ({1'b0, x_q} >= X_LIM) || ({1'b0, y_q} >= Y_LIM);
            end
            OP_DRAW_PIX: begin
                is_draw      = 1'b1;
                region_empty = ({1'b0, x_q} >= X_LIM) || ({1'b0, y_q} >= Y_LIM);
            end
            OP_CLEAR: begin
                is_draw      = 1'b1;
                xs           = '0;
                ys           = '0;
                xe           = X_END;
                ye           = Y_END;
                region_empty = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_fill) state_d = S_FILL;
            S_FILL:  if (bus.mem_ready && last_px) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        start_fill = 1'b0;
        if (state_q == S_IDLE && !empty) begin
            pop        = 1'b1;
            start_fill = is_draw & ~region_empty;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            xmax_q       <= '0;
            ymax_q       <= '0;
            color_q      <= '0;
            fill_color_q <= '0;
            col_q        <= '0;
            row_q        <= '0;
            col_start_q  <= '0;
            col_end_q    <= '0;
            row_end_q    <= '0;
        end else begin
            if (pop) begin
                case (op)
                    OP_SET_X:     x_q     <= opnd[XW-1:0];
                    OP_SET_Y:     y_q     <= opnd[YW-1:0];
                    OP_SET_COLOR: color_q <= opnd[CW-1:0];
                    OP_SET_XMAX:  xmax_q  <= opnd[XW-1:0];
                    OP_SET_YMAX:  ymax_q  <= opnd[YW-1:0];
                    default: ;
                endcase
            end
            if (start_fill) begin
                col_q        <= xs;
                row_q        <= ys;
                col_start_q  <= xs;
                col_end_q    <= xe;
                row_end_q    <= ye;
                fill_color_q <= color_q;
            end else if (state_q == S_FILL && bus.mem_ready) begin
                if (col_q != col_end_q) begin
                    col_q <= col_q + 1'b1;
                end else if (row_q != row_end_q) begin
                    col_q <= col_start_q;
                    row_q <= row_q + 1'b1;
                end
            end
        end
    end
endmodule
